// File: rtl/reg_file_pkg.sv
// Shared widths, types and constants for the LoongArch general-purpose
// register file. The optional feature macro REGFILE_BYPASS_EN is consumed by
// reg_file and reg_file_rport, not by this package.
package reg_file_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // r0 is architecturally hard-wired to zero
    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage : reg_file_pkg

// File: rtl/reg_file_rport.sv
// One combinational read port of the register file.
// Selects the addressed entry, forces r0 to read zero, and when
// REGFILE_BYPASS_EN is defined forwards the in-flight write data to the port
// if it is reading the address being written in the same cycle.
module reg_file_rport
    import reg_file_pkg::*;
(
    input  reg_data_t regs [NUM_REGS],
`ifdef REGFILE_BYPASS_EN
    input  logic      we,
    input  reg_addr_t waddr,
    input  reg_data_t wdata,
`endif
    input  reg_addr_t raddr,
    output reg_data_t rdata
);

`ifdef REGFILE_BYPASS_EN
    logic fwd_hit;

    // Forward only for a real write; a write to r0 is dropped and must not leak
    assign fwd_hit = we && (waddr != ZERO_REG) && (raddr == waddr);
`endif

    // Port data: zero for r0, forwarded data on a bypass hit, stored data otherwise
    always_comb begin
        rdata = regs[raddr];
`ifdef REGFILE_BYPASS_EN
        if (fwd_hit) begin
            rdata = wdata;
        end
`endif
        if (raddr == ZERO_REG) begin
            rdata = '0;
        end
    end

endmodule : reg_file_rport

// File: rtl/reg_file.sv
// 32 x 32-bit general-purpose register file: two combinational read ports,
// one synchronous write port, r0 hard-wired to zero, asynchronous active-low
// clear of every entry.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, each read port
// returns wdata in the same cycle if it reads the address being written.
module reg_file
    import reg_file_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    input  reg_addr_t raddr1,
    output reg_data_t rdata1,
    input  reg_addr_t raddr2,
    output reg_data_t rdata2,
    input  logic      we,
    input  reg_addr_t waddr,
    input  reg_data_t wdata
);

    reg_data_t regs [NUM_REGS];

    // Storage: async clear of all entries; writes to r0 are dropped so it stays zero
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != ZERO_REG)) begin
            regs[waddr] <= wdata;
        end
    end

    reg_file_rport u_rport1 (
        .regs  (regs),
`ifdef REGFILE_BYPASS_EN
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
`endif
        .raddr (raddr1),
        .rdata (rdata1)
    );

    reg_file_rport u_rport2 (
        .regs  (regs),
`ifdef REGFILE_BYPASS_EN
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
`endif
        .raddr (raddr2),
        .rdata (rdata2)
    );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file. Directed steps followed by a randomized
// phase, all checked against an array-based reference model of the register
// file. Build with +define+REGFILE_BYPASS_EN to check the forwarding variant.
module tb_reg_file;
    import reg_file_pkg::*;

    logic      clk;
    logic      resetn;
    reg_addr_t raddr1;
    reg_data_t rdata1;
    reg_addr_t raddr2;
    reg_data_t rdata2;
    logic      we;
    reg_addr_t waddr;
    reg_data_t wdata;

    int checks = 0;
    int errors = 0;

    // Reference model: plain array of architectural register values
    logic [31:0] model [32];

    reg_file dut (
        .clk    (clk),
        .resetn (resetn),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural read value seen right now on a port addressing a
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && (waddr != 5'd0) && (a == waddr)) return wdata;
`endif
        return model[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        check({tag, "_p1"}, rdata1, exp_read(raddr1));
        check({tag, "_p2"}, rdata2, exp_read(raddr2));
    endtask

    // One rising edge; the model commits the write the DUT should commit
    task automatic clock_edge();
        @(posedge clk);
        if (resetn && we && (waddr != 5'd0)) model[waddr] = wdata;
        #1;
    endtask

    task automatic assert_reset();
        resetn = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #1;
    endtask

    task automatic drive_write(input logic w, input logic [4:0] a, input logic [31:0] d);
        we    = w;
        waddr = a;
        wdata = d;
    endtask

    initial begin
        resetn = 1'b1;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr1 = '0;
        raddr2 = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Reset held for 3 cycles, then sweep every address on both ports
        assert_reset();
        raddr1 = 5'd7;
        raddr2 = 5'd31;
        #1;
        check("rst_held_p1", rdata1, 32'h0);
        check("rst_held_p2", rdata2, 32'h0);
        repeat (3) clock_edge();
        resetn = 1'b1;
        #1;
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(31 - a);
            #1;
            check("rst_sweep_p1", rdata1, 32'h0);
            check("rst_sweep_p2", rdata2, 32'h0);
        end

        // Write enable gating
        raddr1 = 5'd1;
        drive_write(1'b0, 5'd1, 32'hFFFFFFFF);
        clock_edge();
        check("we0_no_write", rdata1, 32'h0);
        drive_write(1'b1, 5'd1, 32'h1111FFFF);
        clock_edge();
        we = 1'b0;
        #1;
        check("we1_write", rdata1, 32'h1111FFFF);
        raddr1 = 5'd2;
        raddr2 = 5'd1;
        #1;
        check("we_other_reg", rdata1, 32'h0);
        check("we_port2", rdata2, 32'h1111FFFF);

        // Back-to-back writes r16..r20
        for (int i = 0; i < 5; i++) begin
            drive_write(1'b1, 5'(16 + i), {4{4'(i)}} << 16 | 32'h0000FFFF);
            raddr1 = waddr;
            raddr2 = waddr - 5'd1;
            clock_edge();
            check("b2b_new", rdata1, {4{4'(i)}} << 16 | 32'h0000FFFF);
            check("b2b_prev", rdata2, (i == 0) ? 32'h0 : ({4{4'(i - 1)}} << 16 | 32'h0000FFFF));
        end
        we = 1'b0;
        raddr1 = 5'd21;
        #1;
        check("b2b_r21", rdata1, 32'h0);

        // Retention: r16..r20 unchanged over 5 idle cycles on both ports
        for (int i = 0; i < 5; i++) begin
            raddr1 = 5'(16 + i);
            raddr2 = 5'(20 - i);
            clock_edge();
            check("ret_p1", rdata1, {4{4'(i)}} << 16 | 32'h0000FFFF);
            check("ret_p2", rdata2, {4{4'(4 - i)}} << 16 | 32'h0000FFFF);
        end

        // r0 stays zero even when written
        drive_write(1'b1, 5'd0, 32'hDEADBEEF);
        raddr1 = 5'd0;
        raddr2 = 5'd0;
        #1;
        check("r0_pre_p1", rdata1, 32'h0);
        check("r0_pre_p2", rdata2, 32'h0);
        clock_edge();
        check("r0_post_p1", rdata1, 32'h0);
        check("r0_post_p2", rdata2, 32'h0);

        // Bypass: give r5 a known old value, then read it while rewriting it
        drive_write(1'b1, 5'd5, 32'h12345678);
        clock_edge();
        drive_write(1'b1, 5'd5, 32'hA5A5A5A5);
        raddr1 = 5'd5;
        raddr2 = 5'd5;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_pre", rdata2, 32'hA5A5A5A5);
`else
        check("byp_pre", rdata2, 32'h12345678);
`endif
        check_ports("byp_pre_model");
        clock_edge();
        we = 1'b0;
        #1;
        check("byp_post_p1", rdata1, 32'hA5A5A5A5);
        check("byp_post_p2", rdata2, 32'hA5A5A5A5);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            drive_write(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            #1;
            check_ports("rand_pre");
            clock_edge();
            check_ports("rand_post");
        end

        // Reset mid-sequence: everything reads zero immediately
        we = 1'b0;
        raddr1 = 5'd5;
        raddr2 = 5'd16;
        #1;
        check("mid_before_rst", rdata1, 32'hA5A5A5A5 & 32'h0 | model[5]);
        assert_reset();
        check("mid_rst_p1", rdata1, 32'h0);
        check("mid_rst_p2", rdata2, 32'h0);
        for (int i = 0; i < 8; i++) begin
            raddr1 = 5'($urandom_range(0, 31));
            raddr2 = 5'($urandom_range(0, 31));
            #1;
            check("mid_rst_sweep_p1", rdata1, 32'h0);
            check("mid_rst_sweep_p2", rdata2, 32'h0);
        end
        // A write attempted during reset is discarded
        drive_write(1'b1, 5'd3, 32'hCAFEF00D);
        clock_edge();
        we = 1'b0;
        raddr1 = 5'd3;
        #1;
        check("rst_write_dropped", rdata1, 32'h0);
        resetn = 1'b1;
        #1;
        check("rst_release_r3", rdata1, 32'h0);
        // First write after release lands on the next edge
        drive_write(1'b1, 5'd3, 32'h0BADC0DE);
        clock_edge();
        we = 1'b0;
        #1;
        check("post_rst_write", rdata1, 32'h0BADC0DE);
        check_ports("post_rst_model");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_file
